// File: rtl/hex_pair_pkg.sv
// Shared constants and types for the hex pair collector: ASCII code points,
// character classes, FSM states and error codes.
package hex_pair_pkg;

    // ASCII code points used by the classifier
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_F     = 8'h46;
    localparam logic [7:0] ASC_a     = 8'h61;
    localparam logic [7:0] ASC_f     = 8'h66;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_COMMA = 8'h2C;

    // Distance between lowercase and uppercase letters
    localparam logic [7:0] ASC_CASE_OFS = 8'h20;

    typedef enum logic [1:0] {
        HEX,
        SEP,
        BAD
    } char_class_e;

    typedef enum logic {
        EMPTY,
        HAVE_HI
    } state_e;

    localparam logic [1:0] ERR_BAD     = 2'd0;
    localparam logic [1:0] ERR_SEP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;

endpackage

// File: rtl/ascii_hex_classify.sv
// Combinational ASCII classifier: sorts a character into HEX / SEP / BAD and
// folds lowercase hex letters onto their uppercase code.
module ascii_hex_classify
    import hex_pair_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_e cls,
    output logic [7:0]  norm
);

    // Range checks on the raw code; lowercase a-f shifted down to A-F
    always_comb begin
        cls  = BAD;
        norm = ch;
        if (ch >= ASC_0 && ch <= ASC_9) begin
            cls = HEX;
        end else if (ch >= ASC_A && ch <= ASC_F) begin
            cls = HEX;
        end else if (ch >= ASC_a && ch <= ASC_f) begin
            cls  = HEX;
            norm = ch - ASC_CASE_OFS;
        end else if (ch == ASC_SP || ch == ASC_CR || ch == ASC_LF || ch == ASC_COMMA) begin
            cls = SEP;
        end
    end

endmodule

// File: rtl/hex_pair_collector.sv
// Groups validated hex characters into high/low pairs and offers each pair
// downstream through a single-entry valid/ready output register. Bad input,
// a separator between the two digits, an abandoned partial pair and a pair
// lost to a full output register are all reported on a one-cycle err pulse.
module hex_pair_collector
    import hex_pair_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       char_hi,
    output logic [7:0]       char_lo,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pair_count
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    char_class_e      rx_cls;
    logic [7:0]       rx_norm;

    state_e           state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       char_hi_q, char_hi_d;
    logic [7:0]       char_lo_q, char_lo_d;
    logic             pair_valid_q, pair_valid_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;
    logic             complete;

    ascii_hex_classify u_classify (
        .ch   (rx_data),
        .cls  (rx_cls),
        .norm (rx_norm)
    );

    // Next-state: pair assembly FSM, timeout, output register and handshake
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        tmo_d        = tmo_q;
        char_hi_d    = char_hi_q;
        char_lo_d    = char_lo_q;
        pair_valid_d = pair_valid_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        pair_count_d = pair_count_q;
        complete     = 1'b0;

        // Downstream acceptance frees the output register
        if (pair_valid_q && pair_ready) begin
            pair_valid_d = 1'b0;
            pair_count_d = pair_count_q + CNT_W'(1);
        end

        // An incoming char always takes priority over a pending timeout
        if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                EMPTY: begin
                    case (rx_cls)
                        HEX: begin
                            hi_d    = rx_norm;
                            state_d = HAVE_HI;
                        end
                        BAD: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD;
                        end
                        default: ;
                    endcase
                end
                HAVE_HI: begin
                    state_d = EMPTY;
                    case (rx_cls)
                        HEX: complete = 1'b1;
                        SEP: begin
                            hi_d       = ASC_0;
                            err_d      = 1'b1;
                            err_code_d = ERR_SEP;
                        end
                        default: begin
                            hi_d       = ASC_0;
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD;
                        end
                    endcase
                end
                default: state_d = EMPTY;
            endcase
        end else if (state_q == HAVE_HI) begin
            if (tmo_q == TMO_LAST) begin
                state_d    = EMPTY;
                hi_d       = ASC_0;
                tmo_d      = '0;
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        // Load when the register is empty or being emptied this cycle,
        // otherwise the new pair is dropped and the held one kept
        if (complete) begin
            if (!pair_valid_q || pair_ready) begin
                char_hi_d    = hi_q;
                char_lo_d    = rx_norm;
                pair_valid_d = 1'b1;
            end else begin
                err_d      = 1'b1;
                err_code_d = ERR_OVF;
            end
        end
    end

    // State and output registers; reset drops any pair in flight silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            hi_q         <= ASC_0;
            tmo_q        <= '0;
            char_hi_q    <= ASC_0;
            char_lo_q    <= ASC_0;
            pair_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_BAD;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            tmo_q        <= tmo_d;
            char_hi_q    <= char_hi_d;
            char_lo_q    <= char_lo_d;
            pair_valid_q <= pair_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            pair_count_q <= pair_count_d;
        end
    end

    assign char_hi    = char_hi_q;
    assign char_lo    = char_lo_q;
    assign pair_valid = pair_valid_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_hex_pair_collector.sv
// Directed bench for hex_pair_collector with hand-computed expectations.
module tb_hex_pair_collector;

    localparam int TMO   = 16;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       char_hi;
    logic [7:0]       char_lo;
    logic             pair_valid;
    logic             pair_ready;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] pair_count;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;

    hex_pair_collector #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .char_hi    (char_hi),
        .char_lo    (char_lo),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .err        (err),
        .err_code   (err_code),
        .pair_count (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // err is a one-cycle pulse, so one sample per negedge counts each pulse once
    always @(negedge clk) if (err) err_seen <= err_seen + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ch);
        rx_data  = ch;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hi"},    32'(char_hi),    'h30);
        check({tag, "_lo"},    32'(char_lo),    'h30);
        check({tag, "_pv"},    32'(pair_valid), 0);
        check({tag, "_err"},   32'(err),        0);
        check({tag, "_code"},  32'(err_code),   0);
        check({tag, "_count"}, 32'(pair_count), 0);
    endtask

    int e0;

    initial begin
        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        pair_ready = 1'b0;
        idle(2);
        check_reset_vals("rst");
        rst_n = 1'b1;
        idle(1);

        // Basic pair
        pair_ready = 1'b1;
        drive("3");
        check("basic_pv_early", 32'(pair_valid), 0);
        drive("F");
        check("basic_pv", 32'(pair_valid), 1);
        check("basic_hi", 32'(char_hi), 'h33);
        check("basic_lo", 32'(char_lo), 'h46);
        idle(1);
        check("basic_pv_drop", 32'(pair_valid), 0);
        check("basic_count", 32'(pair_count), 1);

        // Lowercase and separators, back-to-back
        e0 = err_seen;
        drive(8'h20);
        drive("a");
        drive("b");
        check("lc_pv1", 32'(pair_valid), 1);
        check("lc_hi1", 32'(char_hi), 'h41);
        check("lc_lo1", 32'(char_lo), 'h42);
        drive(8'h0D);
        check("lc_count1", 32'(pair_count), 2);
        drive("c");
        drive("0");
        check("lc_hi2", 32'(char_hi), 'h43);
        check("lc_lo2", 32'(char_lo), 'h30);
        idle(1);
        check("lc_count2", 32'(pair_count), 3);
        check("lc_no_err", 32'(err_seen - e0), 0);

        // Bad character mid-pair
        drive("1");
        drive("G");
        check("bad_err", 32'(err), 1);
        check("bad_code", 32'(err_code), 0);
        check("bad_pv", 32'(pair_valid), 0);
        idle(1);
        check("bad_err_pulse", 32'(err), 0);

        // Separator mid-pair
        drive("7");
        drive(8'h20);
        check("sep_err", 32'(err), 1);
        check("sep_code", 32'(err_code), 1);

        // Timeout: err exactly TMO edges after the edge sampling '5'
        drive("5");
        idle(TMO - 1);
        check("tmo_early", 32'(err), 0);
        idle(1);
        check("tmo_err", 32'(err), 1);
        check("tmo_code", 32'(err_code), 2);
        idle(1);
        check("tmo_pulse", 32'(err), 0);
        drive("8");
        drive("9");
        check("tmo_after_hi", 32'(char_hi), 'h38);
        check("tmo_after_lo", 32'(char_lo), 'h39);
        check("tmo_code_held", 32'(err_code), 2);
        idle(1);
        check("tmo_after_count", 32'(pair_count), 4);

        // Back-pressure overflow
        pair_ready = 1'b0;
        drive("1");
        drive("2");
        check("bp_pv", 32'(pair_valid), 1);
        drive("3");
        drive("4");
        check("bp_ovf_err", 32'(err), 1);
        check("bp_ovf_code", 32'(err_code), 3);
        check("bp_hi_held", 32'(char_hi), 'h31);
        check("bp_lo_held", 32'(char_lo), 'h32);
        idle(2);
        check("bp_pv_held", 32'(pair_valid), 1);
        check("bp_hi_stable", 32'(char_hi), 'h31);
        check("bp_count_held", 32'(pair_count), 4);
        pair_ready = 1'b1;
        idle(1);
        check("bp_pv_acc", 32'(pair_valid), 0);
        check("bp_count", 32'(pair_count), 5);
        idle(2);
        check("bp_count_once", 32'(pair_count), 5);

        // Accept and load in the same cycle
        pair_ready = 1'b0;
        drive("1");
        drive("2");
        drive("3");
        e0 = err_seen;
        pair_ready = 1'b1;
        drive("4");
        check("col_pv", 32'(pair_valid), 1);
        check("col_hi", 32'(char_hi), 'h33);
        check("col_lo", 32'(char_lo), 'h34);
        check("col_count", 32'(pair_count), 6);
        check("col_err", 32'(err), 0);
        idle(1);
        check("col_count2", 32'(pair_count), 7);
        check("col_pv_drop", 32'(pair_valid), 0);
        check("col_no_err", 32'(err_seen - e0), 0);

        // Reset mid-pair, with a pair held as well
        pair_ready = 1'b0;
        drive("E");
        drive("D");
        drive("A");
        e0 = err_seen;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        idle(2);
        check_reset_vals("rst_hold");
        rst_n = 1'b1;
        pair_ready = 1'b1;
        idle(1);
        drive("B");
        check("rst_no_half", 32'(pair_valid), 0);
        drive("C");
        check("rst_pv", 32'(pair_valid), 1);
        check("rst_hi", 32'(char_hi), 'h42);
        check("rst_lo", 32'(char_lo), 'h43);
        idle(1);
        check("rst_count", 32'(pair_count), 1);
        check("rst_no_err", 32'(err_seen - e0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_pair_collector.md
# hex_pair_collector

Upstream stage of the memory-controller command path. It takes a stream of ASCII characters from the serial receiver and validates them as hexadecimal digits, normalising lowercase to uppercase. It groups the digits into high/low pairs and presents each completed pair to the hex-to-byte converter through a valid/ready handshake. Malformed input, stalled pairs and a stalled downstream are flagged on a one-cycle error pulse.

## Interface
- TIMEOUT_CYCLES, default 1_000_000: idle cycles allowed between the high and low digit before the partial pair is abandoned (≥2).
- CNT_W, default 16: width of the completed-pair counter.

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  ASCII character from the receiver.
- rx_valid  input  1  one-cycle strobe; rx_data valid in that cycle.
- char_hi  output  8  uppercase ASCII of the high nibble ('0'-'9','A'-'F').
- char_lo  output  8  uppercase ASCII of the low nibble.
- pair_valid  output  1  char_hi/char_lo hold a complete pair.
- pair_ready  input  1  consumer accepts the pair when high together with pair_valid.
- err  output  1  one-cycle pulse on any error event.
- err_code  output  2  cause of the last error: 0 bad char, 1 separator mid-pair, 2 timeout, 3 overflow; held until the next error.
- pair_count  output  CNT_W  count of pairs accepted downstream, wraps at 2^CNT_W.

## Operation
- Character classes:
  - HEX: '0'-'9', 'A'-'F', 'a'-'f'. Lowercase is mapped to uppercase by subtracting 8'h20.
  - SEP: 8'h20 space, 8'h0D CR, 8'h0A LF, 8'h2C comma.
  - BAD: everything else.
- FSM states EMPTY and HAVE_HI.
  - EMPTY, HEX: latch the normalised char into the hi holding register; go to HAVE_HI and clear the timeout counter.
  - EMPTY, SEP: ignored.
  - EMPTY, BAD: err, code 0.
  - HAVE_HI, HEX: the pair completes; go to EMPTY.
  - HAVE_HI, SEP: err, code 1; discard hi; go to EMPTY.
  - HAVE_HI, BAD: err, code 0; discard hi; go to EMPTY.
  - HAVE_HI, no rx_valid: the timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1: err, code 2; go to EMPTY.
  - Any rx_valid clears the timeout counter.
- Output register is a single entry.
  - On pair completion with the register empty, or emptying in this same cycle: load char_hi/char_lo and set pair_valid.
  - On pair completion with the register full and not accepted this cycle: drop the new pair; err, code 3. The held pair is unchanged.
- Handshake:
  - pair_valid && pair_ready clears pair_valid and increments pair_count.
  - char_hi/char_lo are stable while pair_valid=1.
  - pair_valid does not depend combinationally on pair_ready.
- Simultaneous events:
  - Acceptance and completion in the same cycle: the new pair is loaded and pair_valid stays 1.
  - Timeout and rx_valid in the same cycle: rx_valid wins; the char is processed and there is no timeout.
- Reset (any time, including mid-pair or with a pair held): state EMPTY; the holding register, timeout counter and output register are cleared. The pair in flight is lost without any err.

## Timing
- Reset values:
  - char_hi = 8'h30, char_lo = 8'h30.
  - pair_valid = 0, err = 0, err_code = 0, pair_count = 0.
- Latency: pair_valid rises on the clock edge that samples the second HEX char's rx_valid, so it is visible the cycle after the strobe.
- err asserts in the cycle after the offending rx_valid or the timeout expiry, for exactly one cycle.
- Throughput: one char per cycle. rx_valid may be high on consecutive cycles; back-to-back pairs complete every 2 cycles if the consumer holds pair_ready=1.
- No input buffering: the block never back-pressures rx. Loss is reported via code 3 only.

## Structure
- Package hex_pair_pkg holds:
  - ASCII constants: ASC_0, ASC_9, ASC_A, ASC_F, ASC_a, ASC_f, ASC_SP, ASC_CR, ASC_LF, ASC_COMMA.
  - Char-class enum: HEX, SEP, BAD.
  - State enum: EMPTY, HAVE_HI.
  - Error-code constants: ERR_BAD, ERR_SEP, ERR_TIMEOUT, ERR_OVF.
- Sub-module ascii_hex_classify: purely combinational. Takes an 8-bit char and returns its class and the normalised uppercase char. It is instantiated once in hex_pair_collector.
- The timeout counter width is derived from TIMEOUT_CYCLES via $clog2.

## Test plan
- Basic pair: '3','F' with pair_ready=1 → pair_valid=1 for one cycle, char_hi=8'h33, char_lo=8'h46, pair_count=1.
- Lowercase and separators: ' ', 'a', 'b', CR, 'c', '0' → pairs (8'h41, 8'h42) then (8'h43, 8'h30); no err.
- Errors: '1','G' → err, code 0, no pair. '7',' ' → err, code 1. '5' then idle with TIMEOUT_CYCLES=16 → err, code 2 exactly 16 cycles later. A following '8','9' gives pair (8'h38, 8'h39).
- Back-pressure: pair_ready=0, send '1','2' then '3','4' → first pair held stable, err code 3. Raising pair_ready → pair_count=1 and only (8'h31, 8'h32) is seen.
- Accept/load collision: pair_ready=1 asserted in the same cycle '4' completes a '3','4' pair while '1','2' is held → pair_valid stays 1, next data is (8'h33, 8'h34), pair_count increments.
- Reset mid-pair: 'A', then rst_n low for 2 cycles, then 'B','C' → no err; the single pair is (8'h42, 8'h43); all outputs are at reset values during reset.
